// File: rtl/extbus_ctrl.sv
// extbus_ctrl: external-memory bus sequencer for the single-cycle CPU.
// Round-robin CPU/aux arbitration, programmable wait states, tri-state data bus.
module extbus_ctrl #(
    parameter int WAIT = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [15:0] cpu_addr,
    input  logic [15:0] cpu_wdata,
    output logic [15:0] cpu_rdata,
    output logic        cpu_ack,
    output logic        cpu_stall,
    input  logic        aux_req,
    input  logic        aux_we,
    input  logic [15:0] aux_addr,
    input  logic [15:0] aux_wdata,
    output logic [15:0] aux_rdata,
    output logic        aux_ack,
    output logic [15:0] ext_addr,
    output logic        ext_cs,
    output logic        ext_we,
    inout  wire  [15:0] data_bus,
    output logic        busy
);

    localparam logic [3:0] WAIT_LD = 4'(WAIT);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DONE
    } state_t;

    state_t      state;
    logic        last_grant;
    logic        grant;
    logic        lat_we;
    logic [15:0] lat_wdata;
    logic [3:0]  wait_cnt;
    logic        bus_en;

    logic        pick_aux;
    logic        sel_we;
    logic [15:0] sel_addr;
    logic [15:0] sel_wdata;
    logic        last_beat;

    // Round-robin choice: aux wins alone, or on a tie when the CPU went last.
    always_comb begin
        pick_aux  = aux_req & (~cpu_req | ~last_grant);
        sel_we    = pick_aux ? aux_we    : cpu_we;
        sel_addr  = pick_aux ? aux_addr  : cpu_addr;
        sel_wdata = pick_aux ? aux_wdata : cpu_wdata;
        last_beat = (state == ACCESS) && (wait_cnt == 4'd0);
    end

    // Transaction sequencer; every bus-side output is a flop.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            grant      <= 1'b0;
            lat_we     <= 1'b0;
            lat_wdata  <= 16'h0000;
            wait_cnt   <= 4'd0;
            ext_addr   <= 16'h0000;
            ext_cs     <= 1'b0;
            ext_we     <= 1'b0;
            bus_en     <= 1'b0;
            busy       <= 1'b0;
            cpu_ack    <= 1'b0;
            aux_ack    <= 1'b0;
        end else begin
            cpu_ack <= 1'b0;
            aux_ack <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (cpu_req || aux_req) begin
                        grant      <= pick_aux;
                        last_grant <= pick_aux;
                        lat_we     <= sel_we;
                        lat_wdata  <= sel_wdata;
                        ext_addr   <= sel_addr;
                        wait_cnt   <= WAIT_LD;
                        ext_cs     <= 1'b1;
                        ext_we     <= sel_we;
                        bus_en     <= sel_we;
                        busy       <= 1'b1;
                        state      <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (wait_cnt == 4'd0) begin
                        ext_cs  <= 1'b0;
                        ext_we  <= 1'b0;
                        bus_en  <= 1'b0;
                        cpu_ack <= ~grant;
                        aux_ack <= grant;
                        state   <= DONE;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    ext_cs <= 1'b0;
                    ext_we <= 1'b0;
                    bus_en <= 1'b0;
                    busy   <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    // Read data lands in the owner's register at the edge ending the last beat.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cpu_rdata <= 16'h0000;
            aux_rdata <= 16'h0000;
        end else if (last_beat && !lat_we) begin
            if (grant) begin
                aux_rdata <= data_bus;
            end else begin
                cpu_rdata <= data_bus;
            end
        end
    end

    assign data_bus  = bus_en ? lat_wdata : {16{1'bz}};
    assign cpu_stall = cpu_req & ~cpu_ack;

endmodule

// File: tb/tb_extbus_ctrl.sv
// tb_extbus_ctrl: checks extbus_ctrl (WAIT=2 and WAIT=0) against a
// transaction-timeline model plus directed literal expectations.
module tb_extbus_ctrl;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]  creq = '0;
    logic [1:0]  cwe = '0;
    logic [1:0]  areq = '0;
    logic [1:0]  awe = '0;
    logic [15:0] caddr [2];
    logic [15:0] cwdata [2];
    logic [15:0] aaddr [2];
    logic [15:0] awdata [2];
    logic [15:0] crd [2];
    logic [15:0] ard [2];
    logic [15:0] eaddr [2];
    logic [1:0]  cack;
    logic [1:0]  aack;
    logic [1:0]  cstall;
    logic [1:0]  ecs;
    logic [1:0]  ewe;
    logic [1:0]  bsy;
    wire  [15:0] bus0;
    wire  [15:0] bus1;

    int checks = 0;
    int errors = 0;

    // memory contents seen by both instances
    function automatic logic [15:0] mem_val(input logic [15:0] a);
        case (a)
            16'h0040: return 16'hBEEF;
            16'h1234: return 16'hCAFE;
            default:  return a ^ 16'hC3C3;
        endcase
    endfunction

    assign bus0 = (ecs[0] && !ewe[0]) ? mem_val(eaddr[0]) : 16'hzzzz;
    assign bus1 = (ecs[1] && !ewe[1]) ? mem_val(eaddr[1]) : 16'hzzzz;

    extbus_ctrl #(.WAIT(2)) dut0 (
        .clk(clk), .reset(reset),
        .cpu_req(creq[0]), .cpu_we(cwe[0]),
        .cpu_addr(caddr[0]), .cpu_wdata(cwdata[0]),
        .cpu_rdata(crd[0]), .cpu_ack(cack[0]), .cpu_stall(cstall[0]),
        .aux_req(areq[0]), .aux_we(awe[0]),
        .aux_addr(aaddr[0]), .aux_wdata(awdata[0]),
        .aux_rdata(ard[0]), .aux_ack(aack[0]),
        .ext_addr(eaddr[0]), .ext_cs(ecs[0]), .ext_we(ewe[0]),
        .data_bus(bus0), .busy(bsy[0])
    );

    extbus_ctrl #(.WAIT(0)) dut1 (
        .clk(clk), .reset(reset),
        .cpu_req(creq[1]), .cpu_we(cwe[1]),
        .cpu_addr(caddr[1]), .cpu_wdata(cwdata[1]),
        .cpu_rdata(crd[1]), .cpu_ack(cack[1]), .cpu_stall(cstall[1]),
        .aux_req(areq[1]), .aux_we(awe[1]),
        .aux_addr(aaddr[1]), .aux_wdata(awdata[1]),
        .aux_rdata(ard[1]), .aux_ack(aack[1]),
        .ext_addr(eaddr[1]), .ext_cs(ecs[1]), .ext_we(ewe[1]),
        .data_bus(bus1), .busy(bsy[1])
    );

    task automatic tally(input string nm, input int i, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s[%0d] t=%0t got %h expected %h", nm, i, $time, a, e);
        end
    endtask

    task automatic chkb(input string nm, input int i, input logic a, input logic e);
        tally(nm, i, 32'(a), 32'(e));
    endtask

    task automatic chk16(input string nm, input int i, input logic [15:0] a, input logic [15:0] e);
        tally(nm, i, 32'(a), 32'(e));
    endtask

    task automatic chki(input string nm, input int i, input int a, input int e);
        tally(nm, i, a, e);
    endtask

    // Timeline model: a grant at edge e0 gives ACCESS in the WAIT+1 cycles
    // after e0, DONE in the next, and the next grant no earlier than e0+WAIT+3.
    int          ecnt;
    bit          m_act [2];
    bit          m_g [2];
    bit          m_we [2];
    bit          m_last [2];
    int          m_e0 [2];
    logic [15:0] m_addr [2];
    logic [15:0] m_wd [2];
    logic [15:0] m_rd [2][2];

    function automatic int wv(input int i);
        return (i == 0) ? 2 : 0;
    endfunction

    task automatic model_reset();
        ecnt = 0;
        for (int i = 0; i < 2; i++) begin
            m_act[i]   = 1'b0;
            m_g[i]     = 1'b0;
            m_we[i]    = 1'b0;
            m_last[i]  = 1'b1;
            m_e0[i]    = 0;
            m_addr[i]  = 16'h0000;
            m_wd[i]    = 16'h0000;
            m_rd[i][0] = 16'h0000;
            m_rd[i][1] = 16'h0000;
        end
    endtask

    task automatic model_step(input int i);
        bit idle_prev;
        bit pa;
        idle_prev = !m_act[i] || (ecnt - 1 - m_e0[i] >= wv(i) + 2);
        if (m_act[i] && (ecnt - m_e0[i] == wv(i) + 1) && !m_we[i]) begin
            if (m_g[i]) m_rd[i][1] = mem_val(m_addr[i]);
            else        m_rd[i][0] = mem_val(m_addr[i]);
        end
        if (m_act[i] && (ecnt - m_e0[i] >= wv(i) + 2)) m_act[i] = 1'b0;
        if (idle_prev && (creq[i] || areq[i])) begin
            if (creq[i] && areq[i]) pa = !m_last[i];
            else                    pa = areq[i];
            m_last[i] = pa;
            m_g[i]    = pa;
            m_we[i]   = pa ? awe[i] : cwe[i];
            m_addr[i] = pa ? aaddr[i] : caddr[i];
            m_wd[i]   = pa ? awdata[i] : cwdata[i];
            m_e0[i]   = ecnt;
            m_act[i]  = 1'b1;
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge reset);
            if (!reset) begin
                model_reset();
            end else begin
                ecnt++;
                for (int i = 0; i < 2; i++) model_step(i);
            end
        end
    end

    task automatic compare(input int i);
        int          rel;
        bit          acc;
        bit          dn;
        logic        en;
        logic [15:0] bv;
        rel = ecnt - m_e0[i];
        acc = m_act[i] && (rel <= wv(i));
        dn  = m_act[i] && (rel == wv(i) + 1);
        en  = (i == 0) ? dut0.bus_en : dut1.bus_en;
        bv  = (i == 0) ? bus0 : bus1;
        chkb("ext_cs", i, ecs[i], acc);
        chkb("ext_we", i, ewe[i], acc && m_we[i]);
        chkb("bus_en", i, en, acc && m_we[i]);
        chkb("busy", i, bsy[i], acc || dn);
        chkb("cpu_ack", i, cack[i], dn && !m_g[i]);
        chkb("aux_ack", i, aack[i], dn && m_g[i]);
        chkb("cpu_stall", i, cstall[i], creq[i] && !(dn && !m_g[i]));
        chk16("ext_addr", i, eaddr[i], m_addr[i]);
        chk16("cpu_rdata", i, crd[i], m_rd[i][0]);
        chk16("aux_rdata", i, ard[i], m_rd[i][1]);
        if (acc && m_we[i]) chk16("data_bus", i, bv, m_wd[i]);
    endtask

    initial begin
        forever begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) compare(i);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic xfer(input int i, input bit aux, input bit we,
                        input logic [15:0] a, input logic [15:0] wd,
                        output int n, output int cs_n, output int we_n);
        bit ack;
        n = 0;
        cs_n = 0;
        we_n = 0;
        ack = 1'b0;
        if (aux) begin
            awe[i] = we; aaddr[i] = a; awdata[i] = wd; areq[i] = 1'b1;
        end else begin
            cwe[i] = we; caddr[i] = a; cwdata[i] = wd; creq[i] = 1'b1;
        end
        while (!ack && n < 40) begin
            tick();
            n++;
            cs_n += int'(ecs[i]);
            we_n += int'(ewe[i]);
            ack = aux ? aack[i] : cack[i];
        end
        chkb("ack_seen", i, ack, 1'b1);
        if (aux) areq[i] = 1'b0;
        else     creq[i] = 1'b0;
    endtask

    task automatic pulse_reset();
        reset = 1'b0;
        repeat (2) tick();
        reset = 1'b1;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog t=%0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        int cs_n;
        int we_n;
        int cd;
        int ad;
        int acks;
        int at [3];
        int exp_order [3];
        int log_q [$];
        bit seen;
        for (int i = 0; i < 2; i++) begin
            caddr[i] = '0; cwdata[i] = '0; aaddr[i] = '0; awdata[i] = '0;
        end
        exp_order = '{0, 1, 0};
        at = '{0, 0, 0};

        // reset held for 3 cycles
        repeat (3) @(posedge clk);
        #1;
        chkb("rst_cs", 0, ecs[0], 1'b0);
        chkb("rst_busy", 0, bsy[0], 1'b0);
        chk16("rst_addr", 0, eaddr[0], 16'h0000);
        chk16("rst_rdata", 0, crd[0], 16'h0000);
        reset = 1'b1;
        tick();

        // single CPU read of 0x0040
        xfer(0, 1'b0, 1'b0, 16'h0040, 16'h0000, n, cs_n, we_n);
        chki("rd_latency", 0, n, 4);
        chki("rd_cs_cycles", 0, cs_n, 3);
        chki("rd_we_cycles", 0, we_n, 0);
        chk16("rd_data", 0, crd[0], 16'hBEEF);
        tick();

        // CPU write 0x5A5A to 0x0123
        xfer(0, 1'b0, 1'b1, 16'h0123, 16'h5A5A, n, cs_n, we_n);
        chki("wr_latency", 0, n, 4);
        chki("wr_cs_cycles", 0, cs_n, 3);
        chki("wr_we_cycles", 0, we_n, 3);
        chkb("wr_bus_released", 0, dut0.bus_en, 1'b0);
        tick();
        chkb("wr_single_ack", 0, cack[0], 1'b0);

        // three tied grants after reset: CPU, aux, CPU
        pulse_reset();
        cwe[0] = 1'b0; caddr[0] = 16'h0200;
        awe[0] = 1'b1; aaddr[0] = 16'h0300; awdata[0] = 16'h1111;
        creq[0] = 1'b1;
        areq[0] = 1'b1;
        cd = 0;
        ad = 0;
        for (int c = 0; c < 60 && (cd < 2 || ad < 1); c++) begin
            tick();
            if (cack[0]) begin
                log_q.push_back(0);
                cd++;
                if (cd == 2) creq[0] = 1'b0;
            end
            if (aack[0]) begin
                log_q.push_back(1);
                ad++;
                areq[0] = 1'b0;
            end
        end
        creq[0] = 1'b0;
        areq[0] = 1'b0;
        chki("tie_acks", 0, log_q.size(), 3);
        for (int j = 0; j < 3; j++) begin
            chki("tie_order", j, (j < log_q.size()) ? log_q[j] : 9, exp_order[j]);
        end
        tick();

        // reset during the second ACCESS cycle of a write
        cwe[0] = 1'b1; caddr[0] = 16'h0777; cwdata[0] = 16'hA5A5;
        creq[0] = 1'b1;
        tick();
        tick();
        #2;
        reset = 1'b0;
        #1;
        chkb("mid_rst_cs", 0, ecs[0], 1'b0);
        chkb("mid_rst_we", 0, ewe[0], 1'b0);
        chkb("mid_rst_drive", 0, dut0.bus_en, 1'b0);
        chkb("mid_rst_busy", 0, bsy[0], 1'b0);
        creq[0] = 1'b0;
        seen = 1'b0;
        repeat (3) begin
            tick();
            seen = seen | cack[0] | aack[0];
        end
        chkb("mid_rst_no_ack", 0, seen, 1'b0);
        reset = 1'b1;
        tick();
        xfer(0, 1'b0, 1'b0, 16'h0040, 16'h0000, n, cs_n, we_n);
        chki("post_rst_latency", 0, n, 4);
        chk16("post_rst_data", 0, crd[0], 16'hBEEF);
        tick();

        // aux drops its request mid-ACCESS while the CPU waits
        awe[0] = 1'b1; aaddr[0] = 16'h0500; awdata[0] = 16'h2222;
        areq[0] = 1'b1;
        tick();
        cwe[0] = 1'b0; caddr[0] = 16'h0600;
        creq[0] = 1'b1;
        tick();
        areq[0] = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            tick();
            seen = aack[0];
        end
        chkb("drop_aux_ack", 0, seen, 1'b1);
        tick();
        tick();
        chkb("drop_cpu_granted", 0, ecs[0], 1'b1);
        chk16("drop_cpu_addr", 0, eaddr[0], 16'h0600);
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            tick();
            seen = cack[0];
        end
        creq[0] = 1'b0;
        chkb("drop_cpu_ack", 0, seen, 1'b1);
        chk16("drop_cpu_data", 0, crd[0], 16'hC5C3);
        tick();

        // zero wait states
        xfer(1, 1'b0, 1'b0, 16'h1234, 16'h0000, n, cs_n, we_n);
        chki("w0_latency", 1, n, 2);
        chki("w0_cs_cycles", 1, cs_n, 1);
        chk16("w0_data", 1, crd[1], 16'hCAFE);
        tick();
        cwe[1] = 1'b0; caddr[1] = 16'h0040;
        creq[1] = 1'b1;
        acks = 0;
        for (int c = 0; c < 30 && acks < 3; c++) begin
            tick();
            if (cack[1]) begin
                at[acks] = ecnt;
                acks++;
            end
        end
        creq[1] = 1'b0;
        chki("w0_b2b_acks", 1, acks, 3);
        chki("w0_b2b_gap1", 1, at[1] - at[0], 3);
        chki("w0_b2b_gap2", 1, at[2] - at[1], 3);
        chk16("w0_b2b_data", 1, crd[1], 16'hBEEF);
        repeat (3) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/extbus_ctrl.md
# extbus_ctrl

Sequences every external-memory transaction of the single-cycle CPU. It arbitrates the external bus between the CPU datapath and one auxiliary requester, such as a DMA engine or debug port. It inserts a programmable number of wait states, owns the tri-state enable of the shared 16-bit data bus, and stalls the CPU until its access completes. It sits between the datapath's external-address/data outputs and the board-level memory pins.

## Interface
- WAIT, default 2: number of extra bus cycles per access, legal range 0–15.
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low; clears all state immediately.
- cpu_req  in  1  CPU access request; held high until cpu_ack.
- cpu_we  in  1  1 = write, 0 = read; sampled with cpu_req.
- cpu_addr  in  16  CPU byte address; driven from the ALU result.
- cpu_wdata  in  16  CPU write data.
- cpu_rdata  out  16  read data; valid in the cpu_ack cycle and held until the next completed CPU read.
- cpu_ack  out  1  one-cycle completion pulse to the CPU.
- cpu_stall  out  1  equals cpu_req & ~cpu_ack; freezes PC and register writes.
- aux_req, aux_we, aux_addr[15:0], aux_wdata[15:0]  in  auxiliary requester; same rules as the cpu_* inputs.
- aux_rdata  out  16  read data for the auxiliary requester; same rules as cpu_rdata.
- aux_ack  out  1  completion pulse for the auxiliary requester.
- ext_addr  out  16  external address.
- ext_cs  out  1  external chip select.
- ext_we  out  1  external write strobe.
- data_bus  inout  16  shared data bus; driven only during write ACCESS cycles, high-Z otherwise.
- busy  out  1  high whenever the state is not IDLE.

## Operation
- FSM has three states: IDLE, ACCESS and DONE. Reset state is IDLE.
- **IDLE.** If either request is high, grant one requester. Latch its we, addr and wdata into internal registers. Load wait_cnt = WAIT and go to ACCESS. With no request, stay in IDLE.
- **Arbitration** is round-robin using a 1-bit last_grant flag:
  - If only one requester is asking, it wins.
  - If both are asking, the requester that was not granted last wins.
  - last_grant resets to "aux", so the CPU wins the first tie.
  - last_grant updates when a grant is made.
- **ACCESS.**
  - ext_cs = 1 and ext_addr = latched address.
  - On a write, ext_we = 1 and data_bus is driven with the latched wdata.
  - On a read, data_bus is high-Z and ext_we = 0.
  - wait_cnt decrements each cycle.
  - When wait_cnt == 0, a read captures data_bus into the granted requester's rdata register at that edge, and the FSM goes to DONE.
- **DONE.**
  - ext_cs, ext_we and the bus drive are all 0.
  - The granted requester's ack is 1 for exactly this cycle.
  - Next state is IDLE unconditionally. There is no back-to-back grant from DONE, which guarantees one turnaround cycle with the bus undriven.
- **Request dropped mid-transaction:** the transaction still completes and the ack still pulses. Requesters must ignore an ack for a request they abandoned.
- **New input values during ACCESS:** ignored. Only the values latched in IDLE are used.
- The other requester waits while a transaction is in progress. There is no preemption.
- **Reset asserted mid-transaction:**
  - Immediately (asynchronously): ext_cs, ext_we, the bus drive, the acks and busy go to 0, and the state becomes IDLE.
  - The rdata registers clear to 0.
  - The interrupted transaction is lost.

## Timing
- **Reset values:** cpu_rdata, aux_rdata, ext_addr = 0; cpu_ack, aux_ack, ext_cs, ext_we, busy = 0; data_bus = high-Z.
- **Latency:** a request sampled in IDLE at edge k leads to:
  - ACCESS during cycles k+1 … k+1+WAIT, which is WAIT+1 cycles;
  - DONE (ack high) in cycle k+WAIT+2.
  - With WAIT = 2, the ack arrives 4 cycles after the request edge.
- **Read sampling:** read data is sampled at the rising edge that ends the final ACCESS cycle. External memory must have data valid by then.
- **Throughput:** at most one transaction every WAIT+3 cycles (IDLE, ACCESS, DONE).
- **Outputs:** ext_* and the bus enable come directly from registered state and latched values, so they are glitch-free. cpu_stall is combinational from cpu_req.

## Test plan
- **Reset, then single CPU read:** reset low for 3 cycles, WAIT = 2. Memory returns 0xBEEF at address 0x0040 and cpu_req stays high.
  - Required: ext_cs is high for 3 cycles and data_bus stays high-Z throughout.
  - Required: cpu_ack pulses in cycle k+4 with cpu_rdata = 0xBEEF, and cpu_stall is high for cycles k … k+3.
- **CPU write:** addr 0x0123, wdata 0x5A5A.
  - Required: ext_we and ext_cs are high and data_bus = 0x5A5A for 3 cycles.
  - Required: the bus is released in the DONE cycle and cpu_ack pulses once.
- **Simultaneous requests three times in a row:** both requesters assert together.
  - Required grant order: CPU, aux, CPU.
  - Required: each ack pulses exactly once and the grants never overlap.
- **Reset mid-transaction:** reset falls during the second ACCESS cycle of a write.
  - Required: ext_cs, ext_we and the bus drive drop immediately and no ack is issued.
  - Required: after release, a new request completes normally.
- **Dropped request:** aux_req goes low during ACCESS.
  - Required: aux_ack still pulses in DONE, and a pending cpu_req is granted on the following IDLE edge.
- **Zero wait states (WAIT = 0):** read of 0x1234.
  - Required: ACCESS lasts 1 cycle and the ack arrives 2 cycles after the request edge.
  - Required: back-to-back CPU reads complete every 3 cycles.
